// File: rtl/accum_pkg.sv
// Shared types and elaboration helpers for the frame accumulator controller.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    function automatic int unsigned log2_len(input int unsigned frame_len);
        return $clog2(frame_len);
    endfunction

    // Wide enough to hold frame_len full-scale samples without wrapping.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned frame_len);
        return data_w + log2_len(frame_len);
    endfunction

    function automatic bit frame_len_ok(input int unsigned frame_len);
        return (frame_len >= 2) && ((frame_len & (frame_len - 1)) == 0);
    endfunction

endpackage

// File: rtl/accum_datapath.sv
// Frame accumulator register; clear takes priority over enable.
module accum_datapath
    import accum_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ce,
    input  logic [DATA_W-1:0] din,
    output logic [ACC_W-1:0]  acc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (ce) begin
            acc <= acc + ACC_W'(din);
        end
    end

endmodule

// File: rtl/accum_frame_ctrl.sv
// Frame controller: gathers FRAME_LEN samples, then presents their mean
// on a valid/ready output.
module accum_frame_ctrl
    import accum_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam int unsigned LOG2_LEN = log2_len(FRAME_LEN);
    localparam int unsigned ACC_W    = acc_width(DATA_W, FRAME_LEN);
    localparam logic [LOG2_LEN-1:0] LAST_CNT = LOG2_LEN'(FRAME_LEN - 1);

    if (!frame_len_ok(FRAME_LEN)) begin : g_bad_frame_len
        $error("accum_frame_ctrl: FRAME_LEN must be a power of two and at least 2");
    end

    state_t              state_q;
    state_t              state_d;
    logic [LOG2_LEN-1:0] cnt_q;
    logic [ACC_W-1:0]    acc;
    logic                beat;
    logic                clr;
    logic                ce;

    assign beat = in_valid && (state_q == ACCUM);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        ce      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    clr     = 1'b1;
                end
            end
            ACCUM: begin
                // Abort overrides even the final beat; the sum is not committed.
                if (abort) begin
                    state_d = IDLE;
                end else if (beat) begin
                    ce = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr || abort) begin
                cnt_q <= '0;
            end else if (ce) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    accum_datapath #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_datapath (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .ce  (ce),
        .din (in_data),
        .acc (acc)
    );

    // The accumulator itself is the output register; it holds through DONE.
    assign out_data  = DATA_W'(acc >> LOG2_LEN);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// Scoreboard bench for accum_frame_ctrl with FRAME_LEN=4, DATA_W=16.
module tb_accum_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;
    logic [15:0] sb[$];

    accum_frame_ctrl #(
        .DATA_W    (16),
        .FRAME_LEN (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Completed output handshakes are matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready && !abort) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected out_data=%h expected no result", out_data);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                if (out_data !== exp) $display("FAIL sb_result got=%h exp=%h", out_data, exp);
                else passes++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input string name);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (in_ready !== 1'b1) $display("FAIL %s_ready got=%b exp=1", name, in_ready);
        else passes++;
    endtask

    task automatic feed(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Starts a frame, feeds four consecutive beats and checks the result cycle.
    task automatic run_frame(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d,
                             input logic [15:0] exp);
        start_frame(name);
        sb.push_back(exp);
        feed(a);
        feed(b);
        feed(c);
        feed(d);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp)
            $display("FAIL %s_out valid=%b ready=%b data=%h exp valid=1 ready=0 data=%h",
                     name, out_valid, in_ready, out_data, exp);
        else passes++;
    endtask

    task automatic check_idle(input string name);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL %s_idle busy=%b valid=%b ready=%b exp all 0",
                     name, busy, out_valid, in_ready);
        else passes++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0)
            $display("FAIL reset ready=%b valid=%b data=%h busy=%b exp 0/0/0000/0",
                     in_ready, out_valid, out_data, busy);
        else passes++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        run_frame("basic", 16'd10, 16'd20, 16'd30, 16'd40, 16'd25);
        tick();
        check_idle("basic");
    endtask

    task automatic test_worst_case;
        out_ready = 1'b1;
        run_frame("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        total++;
        if (u_dut.acc !== 18'h3FFFC) $display("FAIL max_acc got=%h exp=3fffc", u_dut.acc);
        else passes++;
        tick();
        run_frame("trunc", 16'd1, 16'd0, 16'd0, 16'd0, 16'd0);
        tick();
        check_idle("trunc");
    endtask

    task automatic test_stalls;
        out_ready = 1'b1;
        start_frame("stall");
        sb.push_back(16'd6);
        feed(16'd5);  tick();
        feed(16'd6);  tick();
        feed(16'd7);  tick();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_count valid=%b ready=%b exp 0/1", out_valid, in_ready);
        else passes++;
        feed(16'd9);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'd6)
            $display("FAIL stall_out valid=%b data=%h exp 1/0006", out_valid, out_data);
        else passes++;
        tick();

        out_ready = 1'b0;
        run_frame("bp", 16'd100, 16'd200, 16'd300, 16'd401, 16'd250);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 16'd250 || in_ready !== 1'b0)
                $display("FAIL bp_hold cyc=%0d valid=%b data=%h ready=%b exp 1/00fa/0",
                         i, out_valid, out_data, in_ready);
            else passes++;
        end
        out_ready = 1'b1;
        tick();
        check_idle("bp");
    endtask

    task automatic test_abort;
        out_ready = 1'b1;
        start_frame("abort");
        feed(16'd50);
        feed(16'd60);
        feed(16'd70);
        abort = 1'b1;
        feed(16'd80);
        abort = 1'b0;
        check_idle("abort_last");

        out_ready = 1'b0;
        start_frame("abort_done");
        feed(16'd9); feed(16'd9); feed(16'd9); feed(16'd9);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_done");

        run_frame("after_abort", 16'd4, 16'd4, 16'd4, 16'd4, 16'd4);
        tick();
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        start_frame("rstmid");
        feed(16'd500);
        feed(16'd600);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0)
            $display("FAIL rstmid ready=%b valid=%b data=%h busy=%b exp 0/0/0000/0",
                     in_ready, out_valid, out_data, busy);
        else passes++;

        out_ready = 1'b0;
        start_frame("ign");
        sb.push_back(16'd12);
        start = 1'b1;
        feed(16'd11);
        start = 1'b0;
        feed(16'd12);
        feed(16'd13);
        feed(16'd14);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 16'd12)
            $display("FAIL ign_done valid=%b busy=%b data=%h exp 1/1/000c",
                     out_valid, busy, out_data);
        else passes++;
        out_ready = 1'b1;
        tick();
        check_idle("ign");
    endtask

    task automatic test_back_to_back;
        int t1;
        int t2;
        out_ready = 1'b1;
        run_frame("b2b1", 16'd1, 16'd2, 16'd3, 16'd4, 16'd2);
        t1 = cyc;
        tick();
        run_frame("b2b2", 16'd8, 16'd8, 16'd8, 16'd9, 16'd8);
        t2 = cyc;
        total++;
        if (t2 - t1 !== 6) $display("FAIL b2b_period got=%0d exp=6", t2 - t1);
        else passes++;
        tick();
        check_idle("b2b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_worst_case();
        test_stalls();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        tick();
        total++;
        if (sb.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
